// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, register index width and the IF/ID NOP.
// Latency: none (types and constants). Backpressure: none.
package pipeline_pkg;

    localparam int DEF_REG_ADDR_W = 5;

    localparam logic [1:0] ST_RST_FLUSH = 2'd0;
    localparam logic [1:0] ST_RUN       = 2'd1;
    localparam logic [1:0] ST_STALL2    = 2'd2;

    // addi x0, x0, 0 -- written into IF/ID when the flush path fires
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_RST_FLUSH = ST_RST_FLUSH,
        S_RUN       = ST_RUN,
        S_STALL2    = ST_STALL2
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_bubble;
        logic ifid_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN   = '{pc_write: 1'b1, ifid_write: 1'b1, idex_bubble: 1'b0, ifid_flush: 1'b0};
    localparam ctrl_t CTRL_REDIR = '{pc_write: 1'b1, ifid_write: 1'b1, idex_bubble: 1'b0, ifid_flush: 1'b1};
    localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, idex_bubble: 1'b1, ifid_flush: 1'b0};
    localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_write: 1'b0, idex_bubble: 1'b1, ifid_flush: 1'b1};

endpackage

// File: rtl/hazard_reg_match.sv
// Register hazard compare: does a qualified producer rd feed the ID instruction's rs1/rs2 (x0 excluded).
// Latency: combinational. Backpressure: none.
module hazard_reg_match
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  en,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  uses_rs2,
    output logic                  hit
);

    logic rd_nz;
    logic hit_a;
    logic hit_b;

    assign rd_nz = (rd != '0);
    assign hit_a = rd_nz && (rd == rs1);
    assign hit_b = rd_nz && uses_rs2 && (rd == rs2);
    assign hit   = en && (hit_a || hit_b);

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage stall/flush control for load-use, branch-operand hazards and taken redirects; HAZARD_PERF_CNT_EN adds perf counters.
// Latency: outputs are combinational from state and inputs. Backpressure: stalls hold PC and IF/ID and bubble ID/EX.
module hazard_stall_unit
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] IFIDrs1,
    input  logic [REG_ADDR_W-1:0] IFIDrs2,
    input  logic                  IFID_uses_rs2,
    input  logic                  IFID_branch,
    input  logic                  IFID_jump,
    input  logic                  branch_taken,
    input  logic [REG_ADDR_W-1:0] IDEXrd,
    input  logic                  IDEX_RegWrite,
    input  logic                  IDEX_MemRead,
    input  logic [REG_ADDR_W-1:0] EXMEMrd,
    input  logic                  EXMEM_MemRead,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_bubble,
    output logic                  ifid_flush,
    output logic                  stall_active
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
`endif
);

    hz_state_e state;
    hz_state_e state_nxt;
    ctrl_t     ctrl;

    logic hit_ex_ld;
    logic hit_ex_alu;
    logic hit_mem_ld;
    logic haz_br_ld_ex;
    logic haz_single;
    logic redirect;

    hazard_reg_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_ex_ld (
        .en       (IDEX_MemRead),
        .rd       (IDEXrd),
        .rs1      (IFIDrs1),
        .rs2      (IFIDrs2),
        .uses_rs2 (IFID_uses_rs2),
        .hit      (hit_ex_ld)
    );

    hazard_reg_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_ex_alu (
        .en       (IDEX_RegWrite && !IDEX_MemRead),
        .rd       (IDEXrd),
        .rs1      (IFIDrs1),
        .rs2      (IFIDrs2),
        .uses_rs2 (IFID_uses_rs2),
        .hit      (hit_ex_alu)
    );

    hazard_reg_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_mem_ld (
        .en       (EXMEM_MemRead),
        .rd       (EXMEMrd),
        .rs1      (IFIDrs1),
        .rs2      (IFIDrs2),
        .uses_rs2 (IFID_uses_rs2),
        .hit      (hit_mem_ld)
    );

    // A branch on a load still in EX needs two bubbles; every other hazard clears after one.
    assign haz_br_ld_ex = IFID_branch && hit_ex_ld;
    assign haz_single   = hit_ex_ld || (IFID_branch && (hit_ex_alu || hit_mem_ld));
    assign redirect     = IFID_jump || (IFID_branch && branch_taken);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RST_FLUSH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ctrl      = CTRL_RUN;
        case (state)
            S_RST_FLUSH: begin
                ctrl      = CTRL_RESET;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                // Stall outranks redirect: branch_taken is not trusted while an operand is pending.
                if (haz_br_ld_ex) begin
                    ctrl      = CTRL_STALL;
                    state_nxt = S_STALL2;
                end else if (haz_single) begin
                    ctrl = CTRL_STALL;
                end else if (redirect) begin
                    ctrl = CTRL_REDIR;
                end
            end
            S_STALL2: begin
                ctrl      = CTRL_STALL;
                state_nxt = S_RUN;
            end
            default: begin
                ctrl      = CTRL_RESET;
                state_nxt = S_RST_FLUSH;
            end
        endcase
    end

    assign pc_write     = ctrl.pc_write;
    assign ifid_write   = ctrl.ifid_write;
    assign idex_bubble  = ctrl.idex_bubble;
    assign ifid_flush   = ctrl.ifid_flush;
    assign stall_active = (state != S_RUN) || !ctrl.pc_write;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (state != S_RST_FLUSH) begin
            if (!ctrl.pc_write && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (ctrl.ifid_flush && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit; checks the perf counters when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_stall_unit;

    localparam int RW       = 5;
    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    // {pc_write, ifid_write, idex_bubble, ifid_flush, stall_active}
    localparam logic [4:0] E_RUN   = 5'b11000;
    localparam logic [4:0] E_STALL = 5'b00101;
    localparam logic [4:0] E_FLUSH = 5'b00111;
    localparam logic [4:0] E_REDIR = 5'b11010;

    typedef struct packed {
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic          u2;
        logic          br;
        logic          jp;
        logic          tk;
        logic [RW-1:0] exrd;
        logic          exrw;
        logic          exmr;
        logic [RW-1:0] memrd;
        logic          memmr;
        logic [4:0]    want;
    } stim_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [RW-1:0] IFIDrs1 = '0, IFIDrs2 = '0, IDEXrd = '0, EXMEMrd = '0;
    logic          IFID_uses_rs2 = 1'b0, IFID_branch = 1'b0, IFID_jump = 1'b0, branch_taken = 1'b0;
    logic          IDEX_RegWrite = 1'b0, IDEX_MemRead = 1'b0, EXMEM_MemRead = 1'b0;
    logic          pc_write, ifid_write, idex_bubble, ifid_flush, stall_active;
`ifdef HAZARD_PERF_CNT_EN
    logic [TB_CNT_W-1:0] stall_cycles, flush_count;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    int         m_stall  = 0;
    int         m_flush  = 0;
    logic [4:0] exp_q[$];
    logic [4:0] obs;

    assign obs = {pc_write, ifid_write, idex_bubble, ifid_flush, stall_active};

    always #5 clk = ~clk;

    hazard_stall_unit #(.REG_ADDR_W(RW), .CNT_W(TB_CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .IFIDrs1       (IFIDrs1),
        .IFIDrs2       (IFIDrs2),
        .IFID_uses_rs2 (IFID_uses_rs2),
        .IFID_branch   (IFID_branch),
        .IFID_jump     (IFID_jump),
        .branch_taken  (branch_taken),
        .IDEXrd        (IDEXrd),
        .IDEX_RegWrite (IDEX_RegWrite),
        .IDEX_MemRead  (IDEX_MemRead),
        .EXMEMrd       (EXMEMrd),
        .EXMEM_MemRead (EXMEM_MemRead),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .idex_bubble   (idex_bubble),
        .ifid_flush    (ifid_flush),
        .stall_active  (stall_active)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
`endif
    );

    function automatic stim_t s(input int rs1, input int rs2, input bit u2, input bit br, input bit jp,
                                input bit tk, input int exrd, input bit exrw, input bit exmr,
                                input int memrd, input bit memmr, input logic [4:0] want);
        stim_t r;
        r.rs1 = RW'(rs1);   r.rs2 = RW'(rs2);   r.u2 = u2;   r.br = br;   r.jp = jp;   r.tk = tk;
        r.exrd = RW'(exrd); r.exrw = exrw;      r.exmr = exmr;
        r.memrd = RW'(memrd); r.memmr = memmr;  r.want = want;
        return r;
    endfunction

    task automatic apply(input stim_t st);
        IFIDrs1 = st.rs1;  IFIDrs2 = st.rs2;  IFID_uses_rs2 = st.u2;
        IFID_branch = st.br;  IFID_jump = st.jp;  branch_taken = st.tk;
        IDEXrd = st.exrd;  IDEX_RegWrite = st.exrw;  IDEX_MemRead = st.exmr;
        EXMEMrd = st.memrd;  EXMEM_MemRead = st.memmr;
    endtask

    // Independent counter model: stall cycles and redirect flushes in RUN/STALL2, saturating.
    task automatic account(input logic [4:0] e);
        if (e == E_STALL && m_stall < CNT_MAX) m_stall++;
        if (e == E_REDIR && m_flush < CNT_MAX) m_flush++;
    endtask

    task automatic test_reset();
        logic [4:0] e;
        apply(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) rst = 1'b1;
            if (i == 2) rst = 1'b0;
            exp_q.push_back(i < 3 ? E_FLUSH : E_RUN);
            m_stall = 0;
            m_flush = 0;
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: outputs %b, expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t      t[6];
        logic [4:0] e;
        t[0] = s(5, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, E_STALL);
        t[1] = s(5, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1, E_RUN);
        t[2] = s(1, 6, 0, 0, 0, 0, 6, 1, 1, 0, 0, E_RUN);
        t[3] = s(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, E_RUN);
        t[4] = s(1, 9, 1, 0, 0, 0, 9, 1, 1, 0, 0, E_STALL);
        t[5] = s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
        foreach (t[i]) begin
            @(negedge clk);
            apply(t[i]);
            exp_q.push_back(t[i].want);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL load_use[%0d]: outputs %b, expected %b", i, obs, e);
            end
            account(e);
        end
    endtask

    task automatic test_br_ld_ex();
        stim_t      t[7];
        logic [4:0] e;
        t[0] = s(1, 7, 1, 1, 0, 0, 7, 1, 1, 0, 0, E_STALL);
        t[1] = s(1, 7, 1, 1, 0, 1, 0, 0, 0, 7, 1, E_STALL);
        t[2] = s(1, 7, 1, 1, 0, 1, 0, 0, 0, 0, 0, E_REDIR);
        t[3] = s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
        t[4] = s(8, 0, 0, 1, 0, 0, 8, 1, 1, 0, 0, E_STALL);
        t[5] = s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_STALL);
        t[6] = s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
        foreach (t[i]) begin
            @(negedge clk);
            apply(t[i]);
            exp_q.push_back(t[i].want);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL br_ld_ex[%0d]: outputs %b, expected %b", i, obs, e);
            end
            account(e);
        end
    endtask

    task automatic test_br_alu();
        stim_t      t[8];
        logic [4:0] e;
        t[0] = s(3, 0, 0, 1, 0, 0, 3, 1, 0, 0, 0, E_STALL);
        t[1] = s(3, 0, 0, 1, 0, 0, 0, 0, 0, 3, 0, E_RUN);
        t[2] = s(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, E_RUN);
        t[3] = s(3, 0, 0, 1, 0, 1, 3, 1, 0, 0, 0, E_STALL);
        t[4] = s(3, 0, 0, 1, 0, 1, 0, 0, 0, 3, 0, E_REDIR);
        t[5] = s(4, 0, 0, 1, 0, 0, 0, 0, 0, 4, 1, E_STALL);
        t[6] = s(4, 0, 0, 1, 0, 0, 0, 0, 0, 4, 0, E_RUN);
        t[7] = s(3, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, E_RUN);
        foreach (t[i]) begin
            @(negedge clk);
            apply(t[i]);
            exp_q.push_back(t[i].want);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL br_alu[%0d]: outputs %b, expected %b", i, obs, e);
            end
            account(e);
        end
    endtask

    task automatic test_jump();
        stim_t      t[5];
        logic [4:0] e;
        t[0] = s(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_REDIR);
        t[1] = s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
        t[2] = s(2, 0, 0, 0, 1, 0, 2, 1, 1, 0, 0, E_STALL);
        t[3] = s(2, 0, 0, 0, 1, 0, 0, 0, 0, 2, 1, E_REDIR);
        t[4] = s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
        foreach (t[i]) begin
            @(negedge clk);
            apply(t[i]);
            exp_q.push_back(t[i].want);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL jump[%0d]: outputs %b, expected %b", i, obs, e);
            end
            account(e);
        end
`ifdef HAZARD_PERF_CNT_EN
        n_checks++;
        if (stall_cycles !== TB_CNT_W'(m_stall)) begin
            n_fail++;
            $display("FAIL stall_cycles_mix: got %0d, expected %0d", stall_cycles, m_stall);
        end
        n_checks++;
        if (flush_count !== TB_CNT_W'(m_flush)) begin
            n_fail++;
            $display("FAIL flush_count_mix: got %0d, expected %0d", flush_count, m_flush);
        end
`endif
    endtask

    task automatic test_reset_mid_stall();
        logic [4:0] e;
        @(negedge clk);
        apply(s(1, 7, 1, 1, 0, 0, 7, 1, 1, 0, 0, E_STALL));
        exp_q.push_back(E_STALL);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL mid_stall_first: outputs %b, expected %b", obs, e);
        end
        #2;
        rst = 1'b1;
        m_stall = 0;
        m_flush = 0;
        exp_q.push_back(E_FLUSH);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL mid_stall_rst_now: outputs %b, expected %b", obs, e);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1) begin
                rst = 1'b0;
                apply(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
            end
            exp_q.push_back(i < 2 ? E_FLUSH : E_RUN);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL mid_stall_after[%0d]: outputs %b, expected %b", i, obs, e);
            end
            account(e);
        end
`ifdef HAZARD_PERF_CNT_EN
        n_checks++;
        if (stall_cycles !== '0 || flush_count !== '0) begin
            n_fail++;
            $display("FAIL cnt_after_reset: stall_cycles %0d flush_count %0d, expected 0 0", stall_cycles, flush_count);
        end
`endif
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_cnt();
        logic [4:0] e;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i < 20) apply(s(5, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, E_STALL));
            else        apply(s(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, E_REDIR));
            exp_q.push_back(i < 20 ? E_STALL : E_REDIR);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL perf_seq[%0d]: outputs %b, expected %b", i, obs, e);
            end
            account(e);
        end
        @(negedge clk);
        apply(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        #1;
        n_checks++;
        if (stall_cycles !== TB_CNT_W'(CNT_MAX) || m_stall != CNT_MAX) begin
            n_fail++;
            $display("FAIL stall_cycles_sat: got %0d, expected %0d", stall_cycles, CNT_MAX);
        end
        n_checks++;
        if (flush_count !== TB_CNT_W'(CNT_MAX) || m_flush != CNT_MAX) begin
            n_fail++;
            $display("FAIL flush_count_sat: got %0d, expected %0d", flush_count, CNT_MAX);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_br_ld_ex();
        test_br_alu();
        test_jump();
        test_reset_mid_stall();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Sequential counterpart of the pipeline forwarding logic.
- Handles every hazard that forwarding cannot hide:
  - load-use hazards;
  - branch-in-ID operand hazards, since branches compare in ID after the post-regbank forwarding muxes;
  - control flushes on taken branch or jump.
- Drives PC/IF-ID write enables, ID/EX bubble insertion and IF-ID flush.
- Sits beside the forwarding unit in the ID stage.

Parameters:
- REG_ADDR_W, 5, register index width.
- CNT_W, 32, perf counter width (optional feature only).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- IFIDrs1  in  REG_ADDR_W  rs1 of instruction in ID.
- IFIDrs2  in  REG_ADDR_W  rs2 of instruction in ID.
- IFID_uses_rs2  in  1  ID instruction reads rs2 (R/S/B type).
- IFID_branch  in  1  conditional branch in ID.
- IFID_jump  in  1  JAL/JALR in ID.
- branch_taken  in  1  ID comparator result, valid when IFID_branch.
- IDEXrd  in  REG_ADDR_W  destination in EX.
- IDEX_RegWrite  in  1  EX writes rd.
- IDEX_MemRead  in  1  EX is a load.
- EXMEMrd  in  REG_ADDR_W  destination in MEM.
- EXMEM_MemRead  in  1  MEM is a load.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- idex_bubble  out  1  zero ID/EX control fields.
- ifid_flush  out  1  replace IF/ID with NOP.
- stall_active  out  1  FSM not in RUN or stall asserted this cycle.

Behaviour:
- Hazard terms:
  - hitA(rd) = rd!=0 && rd==IFIDrs1.
  - hitB(rd) = rd!=0 && IFID_uses_rs2 && rd==IFIDrs2.
  - hit(rd) = hitA | hitB.
- Hazards, evaluated in RUN only:
  - LU: IDEX_MemRead && hit(IDEXrd) → 1 stall.
  - BR_ALU: IFID_branch && IDEX_RegWrite && !IDEX_MemRead && hit(IDEXrd) → 1 stall.
  - BR_LD_EX: IFID_branch && IDEX_MemRead && hit(IDEXrd) → 2 stalls. Takes priority over LU.
  - BR_LD_MEM: IFID_branch && EXMEM_MemRead && hit(EXMEMrd) → 1 stall.
- FSM states: RST_FLUSH, RUN, STALL2. State register only; all outputs are Mealy from state and inputs.
- Stall cycle outputs: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
- RST_FLUSH:
  - Entered asynchronously on rst.
  - Outputs while rst high and for one cycle after deassertion: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=1, stall_active=1.
  - Next state: RUN.
- RUN:
  - BR_LD_EX → stall this cycle, next state STALL2.
  - Otherwise any 1-stall hazard → stall this cycle, stay RUN. The bubble advances the producer and the condition re-evaluates next cycle.
  - No hazard and (IFID_jump or IFID_branch && branch_taken) → pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=1.
  - No hazard and no redirect → pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0.
- STALL2:
  - Unconditional stall for exactly one cycle, independent of inputs. This covers the load now sitting in MEM.
  - Next state RUN, which re-evaluates normally.
- Priority: stall beats flush. A taken branch with a pending hazard is not flushed until its stalls clear, because branch_taken is only trusted when no hazard is present.
- Register x0 never causes a stall.
- Latency:
  - Stall outputs are combinational in the same cycle as the hazard.
  - Total stall cycles: LU=1, BR_ALU=1, BR_LD_MEM=1, BR_LD_EX=2.
- stall_active=1 whenever pc_write=0.
- Reset mid-stall: returns to RST_FLUSH immediately. STALL2 progress is discarded.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, two extra output ports are added, each reset to 0:
  - stall_cycles, CNT_W bits: increments every cycle pc_write=0 outside RST_FLUSH.
  - flush_count, CNT_W bits: increments every cycle ifid_flush=1 outside RST_FLUSH.
- Both counters saturate at all-ones.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package pipeline_pkg:
  - state encoding localparams ST_RST_FLUSH, ST_RUN, ST_STALL2;
  - REG_ADDR_W default;
  - a NOP instruction constant used by the IF/ID flush path.
- One natural sub-module, hazard_reg_match: pure compare hit(rd). Instantiated three times.

Test Plan:
- rst pulse, then release → exactly 1 cycle with ifid_flush=1 and pc_write=0 after deassertion, then RUN with pc_write=1.
- EX load, IDEXrd=5, IFIDrs1=5, no branch → 1 cycle with pc_write=0 and idex_bubble=1; next cycle pc_write=1.
- Branch in ID with IFIDrs2=7, IFID_uses_rs2=1, EX load to x7 → 2 consecutive stall cycles, entering STALL2; then branch_taken=1 → ifid_flush=1 with pc_write=1.
- Branch with IDEX ALU op writing x3, IFIDrs1=3 → 1 stall. Same case with IDEXrd=0 → no stall.
- IFID_jump=1 with no hazard → single-cycle ifid_flush=1 and idex_bubble=0.
- Assert rst in the first stall cycle of a BR_LD_EX sequence → outputs switch to RST_FLUSH values immediately and no STALL2 cycle follows.
- Macro defined → after the above sequences, stall_cycles and flush_count equal the cycles counted by the bench; both hold at all-ones when saturated.
